mmio_io_resp: RTL

Memory-mapped I/O responder on the CPU data-memory bus, next to `dram` in the `sccomp_dataflow` top. It decodes a 16-byte I/O window and serves loads and stores from the CPU's bus signals (enable, read/write strobes, address, data, and the Lw/Lh/Lhu/Lb/Lbu/Sw/Sh/Sb width flags). It holds four registers:
- a display register that feeds `seg7x16`;
- a writable free-running cycle counter;
- debounced board switches;
- a sticky switch-change status flag with an interrupt line.

---
 rtl/mmio_io_pkg.sv | 85 ++++++++
 rtl/mmio_io_resp_if.sv | 28 ++
 rtl/sw_debounce.sv | 53 +++++
 rtl/mmio_io_resp.sv | 106 ++++++++++
 4 files changed

// File: rtl/mmio_io_pkg.sv
// Shared constants and lane helpers for the MMIO responder.
package mmio_io_pkg;

  // Register select values for addr[3:2].
  localparam logic [1:0] OFF_DISP   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_SW     = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // STATUS bit carrying the sticky switch-change flag.
  localparam int unsigned ST_SWCHG = 0;

  // Store decoded into byte enables and word-positioned data.
  typedef struct packed {
    logic        valid;
    logic [3:0]  be;
    logic [31:0] data;
  } st_lane_t;

  // Position right-aligned store data into its lanes; misaligned stores come back invalid.
  function automatic st_lane_t store_lane(input logic st_w, input logic st_h, input logic st_b,
                                          input logic [1:0] off, input logic [31:0] wdata);
    st_lane_t r;
    r = '0;
    if (st_w) begin
      if (off == 2'd0) begin
        r.valid = 1'b1;
        r.be    = 4'hf;
        r.data  = wdata;
      end
    end else if (st_h) begin
      if (!off[0]) begin
        r.valid = 1'b1;
        r.be    = off[1] ? 4'hc : 4'h3;
        r.data  = off[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
      end
    end else if (st_b) begin
      r.valid = 1'b1;
      r.be    = 4'b0001 << off;
      r.data  = {24'h000000, wdata[7:0]} << {off, 3'b000};
    end
    return r;
  endfunction

  // Replace the enabled bytes of the old word with the store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input st_lane_t l);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = l.be[i] ? l.data[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  // Pick the addressed lane and extend it; misaligned word/half loads read 0.
  function automatic logic [31:0] load_extract(input logic [31:0] v, input logic ld_w,
                                               input logic ld_h, input logic ld_hu,
                                               input logic ld_b, input logic ld_bu,
                                               input logic [1:0] off);
    logic [31:0] r;
    logic [31:0] shifted;
    logic [15:0] h;
    logic [7:0]  b;
    r       = '0;
    shifted = v >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? v[31:16] : v[15:0];
    if (ld_w && off == 2'd0) begin
      r = v;
    end
    if (ld_h && !off[0]) begin
      r = {{16{h[15]}}, h};
    end
    if (ld_hu && !off[0]) begin
      r = {16'h0000, h};
    end
    if (ld_b) begin
      r = {{24{b[7]}}, b};
    end
    if (ld_bu) begin
      r = {24'h000000, b};
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_io_resp_if.sv
// CPU data-memory bus as seen by the MMIO responder.
interface mmio_io_resp_if;
  logic        cs;
  logic        rena;
  logic        wena;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        Lw;
  logic        Lh;
  logic        Lhu;
  logic        Lb;
  logic        Lbu;
  logic        Sw;
  logic        Sh;
  logic        Sb;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output cs, rena, wena, addr, wdata, Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb,
    input  rdata, hit
  );

  modport slave (
    input  cs, rena, wena, addr, wdata, Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb,
    output rdata, hit
  );
endinterface

// File: rtl/sw_debounce.sv
// Switch synchronizer and tick-sampled debouncer; flags every change of the debounced value.
module sw_debounce #(
  parameter int unsigned N_SW       = 16,
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_q,
  output logic            changed
);

  localparam int unsigned TW = $clog2(DEB_CYCLES);

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] samp_q, samp_d;
  logic [N_SW-1:0] deb_q, deb_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;

  // Tick period counter and next debounced value: a bit moves only when two ticks agree.
  always_comb begin
    tick       = (tick_cnt_q == TW'(DEB_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    samp_d     = samp_q;
    deb_d      = deb_q;
    if (tick) begin
      samp_d = sync2_q;
      deb_d  = (~(sync2_q ^ samp_q) & sync2_q) | ((sync2_q ^ samp_q) & deb_q);
    end
    changed = (deb_d != deb_q);
  end

  // Synchronizer, sample history and debounced state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_q     <= '0;
      deb_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= sw_in;
      sync2_q    <= sync1_q;
      samp_q     <= samp_d;
      deb_q      <= deb_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign sw_q = deb_q;

endmodule

// File: rtl/mmio_io_resp.sv
// MMIO responder: 16-byte window with DISP, COUNT, SW and STATUS registers.
module mmio_io_resp
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h1001_0000,
  parameter int unsigned N_SW       = 16,
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst,
  mmio_io_resp_if.slave   bus,
  input  logic [N_SW-1:0] sw_in,
  output logic [31:0]     disp_data,
  output logic            irq
);

  logic [31:0]     disp_q, disp_d;
  logic [31:0]     count_q, count_d;
  logic            status_q, status_d;
  logic [N_SW-1:0] sw_val;
  logic            sw_changed;
  logic            hit;
  logic [1:0]      sel;
  logic [1:0]      off;
  logic            we;
  logic            w1c;
  st_lane_t        st;
  logic [31:0]     sw_word;
  logic [31:0]     status_word;
  logic [31:0]     reg_rd;

  sw_debounce #(
    .N_SW       (N_SW),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_q    (sw_val),
    .changed (sw_changed)
  );

  // Decode, read mux and zero-latency load path.
  always_comb begin
    hit = bus.cs & (bus.addr[31:4] == BASE[31:4]);
    sel = bus.addr[3:2];
    off = bus.addr[1:0];
    st  = store_lane(bus.Sw, bus.Sh, bus.Sb, off, bus.wdata);
    we  = hit & bus.wena & st.valid;

    sw_word                = '0;
    sw_word[N_SW-1:0]      = sw_val;
    status_word            = '0;
    status_word[ST_SWCHG]  = status_q;

    unique case (sel)
      OFF_DISP:   reg_rd = disp_q;
      OFF_COUNT:  reg_rd = count_q;
      OFF_SW:     reg_rd = sw_word;
      OFF_STATUS: reg_rd = status_word;
      default:    reg_rd = '0;
    endcase

    bus.hit   = hit;
    bus.rdata = '0;
    if (hit && bus.rena) begin
      bus.rdata = load_extract(reg_rd, bus.Lw, bus.Lh, bus.Lhu, bus.Lb, bus.Lbu, off);
    end
  end

  // Register next state; a store to COUNT replaces that cycle's increment.
  always_comb begin
    disp_d  = disp_q;
    count_d = count_q + 32'd1;
    w1c     = 1'b0;
    if (we && sel == OFF_DISP) begin
      disp_d = lane_merge(disp_q, st);
    end
    if (we && sel == OFF_COUNT) begin
      count_d = lane_merge(count_q, st);
    end
    // Only a written byte 0 with its LSB set clears the flag.
    if (we && sel == OFF_STATUS) begin
      w1c = st.be[0] & st.data[0];
    end
    // A new switch change beats a simultaneous clear.
    status_d = sw_changed ? 1'b1 : (w1c ? 1'b0 : status_q);
  end

  // Register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q   <= '0;
      count_q  <= '0;
      status_q <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign disp_data = disp_q;
  assign irq       = status_q;

endmodule
